// File: rtl/nor_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nor_tb_pkg
// Brief   : Shared state encoding, default widths and MISR taps for the
//           NOR gate pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
package nor_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned c_N_IN   = 4;
    localparam int unsigned c_N_OUT  = 3;
    localparam int unsigned c_HOLD_W = 8;
    localparam int unsigned c_SIG_W  = 8;

    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [7:0] c_MISR_TAPS = 8'b1011_1000;

endpackage : nor_tb_pkg
`default_nettype wire

// File: rtl/nor_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : nor_pattern_gen_if
// Brief   : Control, pattern and response signals between the sequencer
//           (slave) and its controller / gate environment (master).
// Revision: 1.0 - initial release
// ============================================================================
interface nor_pattern_gen_if #(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3,
    parameter int HOLD_W = 8,
    parameter int SIG_W  = 8
);
    logic              start;
    logic [HOLD_W-1:0] hold_cycles;
    logic              loop_en;
    logic [N_OUT-1:0]  resp_in;
    logic [N_IN-1:0]   pat_out;
    logic              pat_valid;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  sig_out;

    modport master (
        output start, hold_cycles, loop_en, resp_in,
        input  pat_out, pat_valid, busy, done, sig_out
    );

    modport slave (
        input  start, hold_cycles, loop_en, resp_in,
        output pat_out, pat_valid, busy, done, sig_out
    );
endinterface : nor_pattern_gen_if
`default_nettype wire

// File: rtl/nor_pattern_gen_misr.sv
`default_nettype none
// ============================================================================
// Module  : nor_misr
// Brief   : Multiple-input signature register with enable and sync clear.
// Revision: 1.0 - initial release
// ============================================================================
module nor_misr
    import nor_tb_pkg::*;
#(
    parameter int              SIG_W = c_SIG_W,
    parameter int              N_OUT = c_N_OUT,
    parameter logic [SIG_W-1:0] TAPS = c_MISR_TAPS
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    input  wire logic [N_OUT-1:0] i_resp,
    output logic      [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;
    logic             w_fb;
    logic [SIG_W-1:0] w_next;

    always_comb begin
        w_fb   = ^(r_sig & TAPS);
        w_next = {r_sig[SIG_W-2:0], w_fb} ^ {{(SIG_W-N_OUT){1'b0}}, i_resp};
    end

    // Clear wins over enable so a new sweep always starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= w_next;
        end
    end

    assign o_sig = r_sig;

endmodule : nor_misr
`default_nettype wire

// File: rtl/nor_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : nor_pattern_gen
// Brief   : Exhaustive pattern sweep for a 4-input NOR block with programmable
//           per-pattern hold; optional response MISR under NOR_SIG_MISR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module nor_pattern_gen
    import nor_tb_pkg::*;
#(
    parameter int N_IN   = c_N_IN,
    parameter int N_OUT  = c_N_OUT,
    parameter int HOLD_W = c_HOLD_W,
    parameter int SIG_W  = c_SIG_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nor_pattern_gen_if.slave bus
);

    localparam logic [N_IN-1:0] c_PAT_LAST = {N_IN{1'b1}};

    state_t            r_state;
    logic [N_IN-1:0]   r_pat;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] r_hold_m1;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;

    logic [HOLD_W-1:0] w_hold_m1;
    logic              w_accept;
    logic              w_last_hold;

    // A zero hold request behaves as a hold of one clock
    always_comb begin
        w_hold_m1   = (bus.hold_cycles == '0) ? '0 : bus.hold_cycles - HOLD_W'(1);
        w_accept    = (r_state == IDLE) && bus.start;
        w_last_hold = (r_state == RUN) && (r_hold_cnt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_hold_cnt <= '0;
            r_hold_m1  <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    r_pat  <= '0;
                    if (bus.start) begin
                        r_hold_m1  <= w_hold_m1;
                        r_hold_cnt <= w_hold_m1;
                        r_state    <= RUN;
                        r_valid    <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_hold_cnt == '0) begin
                        r_hold_cnt <= r_hold_m1;
                        if (r_pat == c_PAT_LAST) begin
                            // loop_en only matters at the wrap point
                            if (bus.loop_en) begin
                                r_pat <= '0;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_pat <= r_pat + N_IN'(1);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_pat   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pat_out   = r_pat;
    assign bus.pat_valid = r_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

`ifdef NOR_SIG_MISR_EN
    nor_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .TAPS  (SIG_W'(c_MISR_TAPS))
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_last_hold),
        .i_resp (bus.resp_in),
        .o_sig  (bus.sig_out)
    );
`else
    logic             w_unused_misr_ctl;
    logic [N_OUT-1:0] w_unused_resp;
    assign w_unused_misr_ctl = w_accept ^ w_last_hold;
    assign w_unused_resp     = bus.resp_in;
    assign bus.sig_out       = {SIG_W{1'b0}};
`endif

endmodule : nor_pattern_gen
`default_nettype wire

// File: tb/tb_nor_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_nor_pattern_gen
// Brief   : Directed self-checking bench for nor_pattern_gen (MISR checks
//           active when NOR_SIG_MISR_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
module tb_nor_pattern_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   resp_mode = 1;   // 0: outputs tied low, 1: good gate, 2: E stuck-at-1

    nor_pattern_gen_if #(.N_IN(4), .N_OUT(3), .HOLD_W(8), .SIG_W(8)) bus ();

    nor_pattern_gen #(.N_IN(4), .N_OUT(3), .HOLD_W(8), .SIG_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Gate model: E = NOR(A,B,C,D), F = NOR(A,B), G = NOR(C,D)
    function automatic logic [2:0] gate(input logic [3:0] p, input int mode);
        logic e, f, g;
        e = ~|p;
        f = ~(p[0] | p[1]);
        g = ~(p[2] | p[3]);
        if (mode == 0) return 3'b000;
        if (mode == 2) return {g, f, 1'b1};
        return {g, f, e};
    endfunction

    function automatic logic [7:0] model_sig(input int mode);
        logic [7:0] s;
        logic       fb;
        s = 8'h00;
        for (int k = 0; k < 16; k++) begin
            fb = s[7] ^ s[5] ^ s[4] ^ s[3];
            s  = {s[6:0], fb} ^ {5'b0, gate(4'(k), mode)};
        end
        return s;
    endfunction

    always_comb bus.resp_in = gate(bus.pat_out, resp_mode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pat"},   32'(bus.pat_out),   32'd0);
        chk({tag, "_valid"}, 32'(bus.pat_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
    endtask

    // Full sweep; hold_cycles is scrambled right after acceptance to prove it is latched
    task automatic run_sweep(input int hold_in, input string tag);
        int h;
        h = (hold_in == 0) ? 1 : hold_in;
        bus.hold_cycles = 8'(hold_in);
        bus.loop_en     = 1'b0;
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.hold_cycles = ~8'(hold_in);
        for (int j = 0; j < 16 * h; j++) begin
            chk({tag, "_pat"},   32'(bus.pat_out),   32'(j / h));
            chk({tag, "_valid"}, 32'(bus.pat_valid), 32'd1);
            chk({tag, "_busy"},  32'(bus.busy),      32'd1);
            chk({tag, "_done"},  32'(bus.done),      32'd0);
            tick();
        end
        chk({tag, "_done_pulse"}, 32'(bus.done),      32'd1);
        chk({tag, "_done_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done_valid"}, 32'(bus.pat_valid), 32'd0);
        chk({tag, "_done_pat"},   32'(bus.pat_out),   32'd15);
        tick();
        chk_idle({tag, "_after"});
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start       = 1'b0;
        bus.hold_cycles = 8'd0;
        bus.loop_en     = 1'b0;

        // Reset release with no start
        #12;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) tick();
        chk_idle("rst");
        chk("rst_sig", 32'(bus.sig_out), 32'd0);

        // Basic sweeps
        resp_mode = 1;
        run_sweep(1, "h1");
`ifdef NOR_SIG_MISR_EN
        chk("sig_good", 32'(bus.sig_out), 32'(model_sig(1)));
`else
        chk("sig_off", 32'(bus.sig_out), 32'd0);
`endif
        run_sweep(3, "h3");
        run_sweep(0, "h0");

        // Looping sweep, hold 2: wraps at j=32, loop_en dropped mid second pass
        bus.hold_cycles = 8'd2;
        bus.loop_en     = 1'b1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 64; j++) begin
            chk("loop_pat",  32'(bus.pat_out), 32'((j / 2) % 16));
            chk("loop_done", 32'(bus.done),    32'd0);
            chk("loop_busy", 32'(bus.busy),    32'd1);
            if (j == 40) bus.loop_en = 1'b0;
            tick();
        end
        chk("loop_end_done", 32'(bus.done), 32'd1);
        chk("loop_end_pat",  32'(bus.pat_out), 32'd15);
        tick();
        chk_idle("loop_after");

        // Asynchronous reset while pattern 7 is driven
        bus.hold_cycles = 8'd1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        chk("abort_pre_pat", 32'(bus.pat_out), 32'd7);
        #2 rst = 1'b1;
        #1;
        chk_idle("abort");
        chk("abort_sig", 32'(bus.sig_out), 32'd0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            chk("abort_no_done", 32'(bus.done), 32'd0);
            tick();
        end

        // start pulses during RUN are ignored
        bus.hold_cycles = 8'd1;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            chk("ign_pat",  32'(bus.pat_out), 32'(j));
            chk("ign_done", 32'(bus.done),    32'd0);
            bus.start = (j == 5) || (j == 9) || (j == 15);
            tick();
        end
        bus.start = 1'b0;
        chk("ign_done_pulse", 32'(bus.done), 32'd1);
        tick();
        chk_idle("ign_after");

        // Signature with responses tied low and with a stuck-at gate
        resp_mode = 0;
        run_sweep(2, "zero");
`ifdef NOR_SIG_MISR_EN
        chk("sig_zero", 32'(bus.sig_out), 32'd0);
`else
        chk("sig_zero_off", 32'(bus.sig_out), 32'd0);
`endif
        resp_mode = 2;
        run_sweep(1, "stuck");
`ifdef NOR_SIG_MISR_EN
        chk("sig_stuck_model", 32'(bus.sig_out), 32'(model_sig(2)));
        chk("sig_stuck_differs", 32'(bus.sig_out != model_sig(1)), 32'd1);
`else
        chk("sig_stuck_off", 32'(bus.sig_out), 32'd0);
`endif
        resp_mode = 1;
        run_sweep(1, "good2");
`ifdef NOR_SIG_MISR_EN
        chk("sig_good2", 32'(bus.sig_out), 32'(model_sig(1)));
        repeat (5) tick();
        chk("sig_hold_idle", 32'(bus.sig_out), 32'(model_sig(1)));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nor_pattern_gen
`default_nettype wire
